// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types for the hex keypad scanner: FSM states, scan classification
// and the row/column to hex-code key map.
package ee354_keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_kind_e;

  // Pmod KYPD legend: row 3 reads 0 F E D left to right.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and result signals of the hex keypad scanner.
// slave = scanner side, master = keypad/consumer side.
interface hex_keypad_scanner_if;
  logic [3:0]  Row;
  logic        Clear;
  logic [3:0]  Col;
  logic        Key_Valid;
  logic [3:0]  Key_Code;
  logic        Key_Held;
  logic [15:0] Value;

  modport slave (
    input  Row, Clear,
    output Col, Key_Valid, Key_Code, Key_Held, Value
  );

  modport master (
    output Row, Clear,
    input  Col, Key_Valid, Key_Code, Key_Held, Value
  );
endinterface

// File: rtl/hex_keypad_col_scan.sv
// Column drive and row sampling: synchronizes Row, walks the active-low column,
// and classifies each full 4-column scan as NONE / SINGLE(code) / MULTI.
module hex_keypad_col_scan
  import ee354_keypad_pkg::*;
#(
  parameter int SCAN_DIV_W = 17
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       scan_done_o,
  output scan_kind_e scan_kind_o,
  output logic [3:0] scan_code_o
);

  localparam logic [SCAN_DIV_W-1:0] CNT_ONE = SCAN_DIV_W'(1);

  logic [3:0]            row_meta_q, row_sync_q;
  logic [SCAN_DIV_W-1:0] col_cnt_q;
  logic [1:0]            col_idx_q;
  logic [1:0]            hits_q, hits_d;   // keys seen so far this scan, saturates at 2
  logic [3:0]            code_q, code_d;
  logic                  col_max;
  logic [2:0]            col_pop;
  logic [1:0]            col_row;
  logic [2:0]            hit_sum;

  assign col_max     = &col_cnt_q;
  assign scan_done_o = col_max && (col_idx_q == 2'd3);
  assign col_o       = ~(4'b0001 << col_idx_q);

  // NOTE: the reset branch is synchronous because Reset is only sampled on
  // the clock edge; there is no asynchronous path into these flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      col_cnt_q  <= '0;
      col_idx_q  <= '0;
      hits_q     <= '0;
      code_q     <= '0;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
      col_cnt_q  <= col_cnt_q + CNT_ONE;
      if (col_max) begin
        col_idx_q <= col_idx_q + 2'd1;
        if (scan_done_o) begin
          hits_q <= '0;
          code_q <= '0;
        end else begin
          hits_q <= hits_d;
          code_q <= code_d;
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the loop or the ifs can leave a value unassigned and infer a latch.
  always_comb begin
    col_pop = '0;
    col_row = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_pop = col_pop + 3'd1;
        col_row = 2'(r);
      end
    end
    hit_sum = {1'b0, hits_q} + col_pop;
    hits_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_d  = (hits_q == 2'd0 && col_pop == 3'd1) ? keymap(col_row, col_idx_q) : code_q;
    case (hits_d)
      2'd0:    scan_kind_o = SCAN_NONE;
      2'd1:    scan_kind_o = SCAN_SINGLE;
      default: scan_kind_o = SCAN_MULTI;
    endcase
    scan_code_o = code_d;
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Hex keypad scanner top: debounce FSM, key event pulse and hex entry register.
// Optional auto-repeat while a key is held is enabled by KEYPAD_AUTOREPEAT_EN.
module hex_keypad_scanner
  import ee354_keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 40
) (
  input  logic                Clk,
  input  logic                Reset,
  hex_keypad_scanner_if.slave kp
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  logic        scan_done;
  scan_kind_e  scan_kind;
  logic [3:0]  scan_code;
  logic [3:0]  col;

  kp_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        accept_d;
  logic        repeat_fire;
  logic        event_d;
  logic        key_valid_q;
  logic [3:0]  key_code_q;
  logic [15:0] value_q;
  logic        key_held;

  hex_keypad_col_scan #(
    .SCAN_DIV_W(SCAN_DIV_W)
  ) u_col_scan (
    .Clk        (Clk),
    .Reset      (Reset),
    .row_i      (kp.Row),
    .col_o      (col),
    .scan_done_o(scan_done),
    .scan_kind_o(scan_kind),
    .scan_code_o(scan_code)
  );

  // NOTE: state flops take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_code;
            if (DEB_LAST == 4'd1) begin
              state_d  = ST_PRESSED;
              cnt_d    = '0;
              accept_d = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (scan_kind == SCAN_SINGLE && scan_code == cand_q) begin
            if (cnt_q + 4'd1 >= DEB_LAST) begin
              state_d  = ST_PRESSED;
              cnt_d    = '0;
              accept_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scan_kind == SCAN_SINGLE) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (scan_kind == SCAN_NONE) begin
            state_d = (DEB_LAST == 4'd1) ? ST_IDLE : ST_RELEASE;
            cnt_d   = (DEB_LAST == 4'd1) ? 4'd0 : 4'd1;
          end
        end
        default: begin
          if (scan_kind != SCAN_NONE) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q + 4'd1 >= DEB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Only consecutive SINGLE scans while already pressed advance the repeat count.
  always_comb begin
    rpt_d       = rpt_q;
    repeat_fire = 1'b0;
    if (scan_done) begin
      if (state_q == ST_PRESSED && scan_kind == SCAN_SINGLE) begin
        if (rpt_q + RPT_ONE >= RPT_LAST) begin
          rpt_d       = '0;
          repeat_fire = 1'b1;
        end else begin
          rpt_d = rpt_q + RPT_ONE;
        end
      end else begin
        rpt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign event_d = accept_d | repeat_fire;

  // Clear wins over a same-edge key event for Value only; the pulse and code still go out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      value_q     <= '0;
    end else begin
      key_valid_q <= event_d;
      if (event_d) key_code_q <= cand_d;
      if (kp.Clear)    value_q <= '0;
      else if (event_d) value_q <= {value_q[11:0], cand_d};
    end
  end

  always_comb begin
    key_held = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  end

  assign kp.Col       = col;
  assign kp.Key_Valid = key_valid_q;
  assign kp.Key_Code  = key_code_q;
  assign kp.Key_Held  = key_held;
  assign kp.Value     = value_q;

endmodule
